// File: rtl/vga_timing_pkg.sv
// VGA/VESA raster timing types, presets and helpers.
// Shared by the axis counter and the timer top.
package vga_timing_pkg;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
    logic      hpol;
    logic      vpol;
  } vga_mode_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
  } vga_flags_t;

  localparam vga_mode_t VGA_640X480_60 = '{
    h: '{16'd640, 16'd16, 16'd96, 16'd48},
    v: '{16'd480, 16'd10, 16'd2, 16'd33},
    hpol: 1'b0,
    vpol: 1'b0
  };

  localparam vga_mode_t SVGA_800X600_60 = '{
    h: '{16'd800, 16'd40, 16'd128, 16'd88},
    v: '{16'd600, 16'd1, 16'd4, 16'd23},
    hpol: 1'b1,
    vpol: 1'b1
  };

  function automatic int unsigned total(vga_axis_t a);
    return int'(a.active) + int'(a.fp) + int'(a.sync) + int'(a.bp);
  endfunction

endpackage

// File: rtl/vga_timer_param_axis.sv
// One raster axis: wrapping counter plus sync/active decode.
// Horizontal and vertical axes are both built from this.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter vga_axis_t   AXIS = VGA_640X480_60.h,
  parameter int unsigned W    = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         step_i,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         sync_active,
  output logic         active
);

  localparam int unsigned TOTAL = total(AXIS);
  localparam int unsigned S0_I  = int'(AXIS.active) + int'(AXIS.fp);
  localparam int unsigned S1_I  = S0_I + int'(AXIS.sync);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT  = W'(int'(AXIS.active));
  localparam logic [W-1:0] S0   = W'(S0_I);
  localparam logic [W-1:0] S1   = W'(S1_I);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (step_i) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

  assign wrap        = (count == LAST);
  assign sync_active = (count >= S0) && (count < S1);
  assign active      = (count < ACT);

endmodule

// File: rtl/vga_timer_param.sv
// Parametrised VGA raster timer with pixel enable, strobes,
// frame counter and optional sync/visible pipeline delay.
module vga_timer_param
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          HSYNC_POL  = 1'b0,
  parameter bit          VSYNC_POL  = 1'b0,
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned FRAME_W    = 8,
  parameter int unsigned PIPE_DELAY = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               visible_o,
  output logic [COORD_W-1:0] position_x_o,
  output logic [COORD_W-1:0] position_y_o,
  output logic               line_start_o,
  output logic               frame_start_o,
  output logic [FRAME_W-1:0] frame_count_o
);

  localparam vga_axis_t H_AXIS = '{
    16'(H_ACTIVE), 16'(H_FP), 16'(H_SYNC), 16'(H_BP)};
  localparam vga_axis_t V_AXIS = '{
    16'(V_ACTIVE), 16'(V_FP), 16'(V_SYNC), 16'(V_BP)};

  localparam longint H_TOTAL = longint'(total(H_AXIS));
  localparam longint V_TOTAL = longint'(total(V_AXIS));
  localparam longint C_MAX   = longint'(1) << COORD_W;

  if (H_TOTAL > C_MAX || V_TOTAL > C_MAX ||
      H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 ||
      H_BP == 0 || V_ACTIVE == 0 || V_FP == 0 ||
      V_SYNC == 0 || V_BP == 0 || COORD_W == 0 ||
      FRAME_W == 0 || PIPE_DELAY > 4) begin : g_bad
    $error("vga_timer_param: illegal parameters");
  end

  logic       h_wrap, h_sync, h_act;
  logic       v_wrap, v_sync, v_act;
  vga_flags_t raw, dly;

  vga_axis_counter #(.AXIS(H_AXIS), .W(COORD_W)) u_h (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .step_i      (en_i),
    .count       (position_x_o),
    .wrap        (h_wrap),
    .sync_active (h_sync),
    .active      (h_act)
  );

  vga_axis_counter #(.AXIS(V_AXIS), .W(COORD_W)) u_v (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .step_i      (en_i && h_wrap),
    .count       (position_y_o),
    .wrap        (v_wrap),
    .sync_active (v_sync),
    .active      (v_act)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      frame_count_o <= '0;
    end else if (en_i && h_wrap && v_wrap) begin
      frame_count_o <= frame_count_o + 1'b1;
    end
  end

  assign raw = '{hs: h_sync, vs: v_sync, vis: h_act && v_act};

  // Flags are stored as "active" bits so reset zeros mean inactive.
  if (PIPE_DELAY == 0) begin : g_nodly
    assign dly = raw;
  end else begin : g_dly
    vga_flags_t pipe [PIPE_DELAY];
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(PIPE_DELAY); i++)
          pipe[i] <= '0;
      end else if (en_i) begin
        pipe[0] <= raw;
        for (int i = 1; i < int'(PIPE_DELAY); i++)
          pipe[i] <= pipe[i-1];
      end
    end
    assign dly = pipe[PIPE_DELAY-1];
  end

  assign hsync_o   = dly.hs ? HSYNC_POL : ~HSYNC_POL;
  assign vsync_o   = dly.vs ? VSYNC_POL : ~VSYNC_POL;
  assign visible_o = dly.vis;

  assign line_start_o  = en_i && (position_x_o == '0);
  assign frame_start_o = line_start_o && (position_y_o == '0);

endmodule

// File: doc/vga_timer_param.md
Name: vga_timer_param

Overview:
Parametrised VGA/VESA raster timing generator, successor to the fixed 640x480 timer. Timing, sync polarity, coordinate width and sync-to-pixel pipeline alignment are all set by parameters. Adds a pixel-clock enable so the block can run on a faster system clock. Adds line/frame strobes and a frame counter. Sits between the clock/reset domain and the pixel renderer, driving the VGA connector syncs and the renderer's x/y.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, active level of hsync_o (0 = active-low)
VSYNC_POL, 0, active level of vsync_o (0 = active-low)
COORD_W, 10, width of position outputs and internal counters
FRAME_W, 8, width of frame counter
PIPE_DELAY, 0, enabled ticks by which hsync/vsync/visible lag position (0..4)

Ports:
clk_i  input  1  single clock, all logic on rising edge
rst_ni  input  1  synchronous reset, active-low
en_i  input  1  pixel tick; counters advance only when high
hsync_o  output  1  horizontal sync, polarity HSYNC_POL
vsync_o  output  1  vertical sync, polarity VSYNC_POL
visible_o  output  1  high when the (delayed) pixel is in the active area
position_x_o  output  COORD_W  current horizontal count, 0..H_TOTAL-1
position_y_o  output  COORD_W  current vertical count, 0..V_TOTAL-1
line_start_o  output  1  one-clk pulse: en_i high and x==0
frame_start_o  output  1  one-clk pulse: en_i high and x==0 and y==0
frame_count_o  output  FRAME_W  completed-frame count, wraps

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Elaboration $error if H_TOTAL or V_TOTAL > 2**COORD_W, any parameter is 0, or PIPE_DELAY > 4.
- Reset (rst_ni low at a clock edge): x=0, y=0, frame_count=0, delay pipeline filled with inactive values (sync deasserted, visible=0). Reset overrides en_i. Mid-frame reset restarts at (0,0) on the next cycle.
- en_i high: x <= (x==H_TOTAL-1) ? 0 : x+1. y advances only when x==H_TOTAL-1: y <= (y==V_TOTAL-1) ? 0 : y+1. frame_count increments (mod 2**FRAME_W) when x==H_TOTAL-1 and y==V_TOTAL-1.
- en_i low: all state frozen, including delay pipeline. Strobes are 0.
- Raw decode from counters:
  - hsync active for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
  - vsync active for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC.
  - visible = (x < H_ACTIVE) && (y < V_ACTIVE).
  - Output level = active ? POL : ~POL.
- PIPE_DELAY=0:
  - hsync_o/vsync_o/visible_o are the raw decode of current x/y (combinational from registers).
  - Immediately after reset, visible_o=1 at (0,0).
- PIPE_DELAY=N>0:
  - Raw hsync/vsync/visible pass through an N-stage shift register advanced only on en_i.
  - Outputs reflect the decode of the position N enabled ticks earlier.
  - Position and strobes are never delayed.
  - For the first N ticks after reset, outputs are inactive.
- line_start_o/frame_start_o are combinational: en_i AND counter condition. They are high once per line/frame for one clk.
- Simultaneous line and frame wrap: both strobes high on the same cycle at (0,0).

Decomposition:
- Package vga_timing_pkg:
  - struct vga_axis_t {active, fp, sync, bp}.
  - Localparam presets VGA_640X480_60 (H 640/16/96/48, V 480/10/2/33, both polarities 0) and SVGA_800X600_60 (H 800/40/128/88, V 600/1/4/23, both polarities 1).
  - total() function.
- One sub-module, vga_axis_counter: parametrised by the axis timing, with inputs step_i (the advance condition) and outputs count, wrap, sync_active, active. Instantiated once per axis: the horizontal instance steps on en_i; the vertical instance steps on en_i && h_wrap.

Test Plan:
- Defaults, reset held 3 clks then en_i=1 constant:
  - x=0, y=0, visible_o=1, hsync_o=1 after reset.
  - hsync_o low exactly for x 656..751.
  - x wraps 799->0 and y increments.
- Defaults, run to y=489..492: vsync_o low only on lines 490 and 491; frame_start_o pulses once per 420000 ticks; frame_count_o=1 after first full frame.
- en_i toggled every other clk:
  - Counters advance only on en_i cycles; line period is 1600 clks.
  - Strobes never high while en_i=0.
- PIPE_DELAY=2, defaults:
  - visible_o falls 2 enabled ticks after x goes 639->640.
  - hsync_o falls at x=658.
  - Outputs inactive for the first 2 ticks after reset.
- SVGA_800X600_60 preset, COORD_W=11:
  - hsync_o high (active-high) for x 840..967; H_TOTAL=1056.
  - vsync_o high for y 601..604; V_TOTAL=628.
- Reset asserted at x=300, y=200:
  - Next cycle x=0, y=0, frame_count_o unchanged? No — frame_count_o=0.
  - Delay pipeline cleared.
  - frame_start_o pulses on the first enabled tick after reset release.
